// File: rtl/core_pkg.sv
// Shared types for the memory-access / write-back stage: FSM states and the
// write-back control bundle that travels with each retiring instruction.
package core_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_e;

   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_to_reg;
   } wb_bundle_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting on the data memory; expired is high during the
// TIMEOUT_CYC-th enabled cycle after a clear.
module mem_timeout_counter #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYC);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable && (r_cnt != TOP)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Counter holds (n-1) in the n-th wait cycle, so expiry lands on cycle TIMEOUT_CYC.
   assign expired = enable && (r_cnt == LAST);

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage plus MEM/WB pipeline register: issues one load/store at a
// time to a variable-latency data memory and registers the write-back operands.
module mem_wb_stage
   import core_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_alu_result,
   input  logic [WIDTH-1:0]      in_store_data,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic                  in_reg_write,
   input  logic                  in_mem_read,
   input  logic                  in_mem_write,
   input  logic                  flush,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [WIDTH-1:0]      dmem_addr,
   output logic [WIDTH-1:0]      dmem_wdata,
   input  logic                  dmem_rvalid,
   input  logic [WIDTH-1:0]      dmem_rdata,
   output logic                  wb_valid,
   output logic [WIDTH-1:0]      wb_alu_result,
   output logic [WIDTH-1:0]      wb_read_data,
   output logic                  wb_mem_to_reg,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  wb_reg_write,
   output logic                  mem_err
);

   mem_state_e            r_state;
   logic [WIDTH-1:0]      r_addr;
   logic [WIDTH-1:0]      r_wdata;
   logic [REG_ADDR_W-1:0] r_rd;
   logic                  r_reg_write;
   logic                  r_is_load;
   logic                  r_we;
   logic                  r_killed;
   logic                  r_wb_valid;
   logic [WIDTH-1:0]      r_wb_alu;
   logic [WIDTH-1:0]      r_wb_rdata;
   wb_bundle_t            r_wb;

   mem_state_e            w_next_state;
   logic                  w_accept_alu;
   logic                  w_accept_mem;
   logic                  w_retire;
   logic                  w_timeout;
   logic                  w_kill;
   logic                  w_expired;

   mem_timeout_counter #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (r_state == REQ),
      .enable  (r_state == WAIT),
      .expired (w_expired)
   );

   always_comb begin
      w_next_state = r_state;
      w_accept_alu = 1'b0;
      w_accept_mem = 1'b0;
      w_retire     = 1'b0;
      w_timeout    = 1'b0;
      w_kill       = r_killed | flush;
      case (r_state)
         IDLE: begin
            if (in_valid && !flush) begin
               if (in_mem_read || in_mem_write) begin
                  w_accept_mem = 1'b1;
                  w_next_state = REQ;
               end else begin
                  w_accept_alu = 1'b1;
               end
            end
         end
         REQ: w_next_state = WAIT;
         WAIT: begin
            // A response in the expiry cycle still counts as a normal completion.
            if (dmem_rvalid) begin
               w_retire     = 1'b1;
               w_next_state = IDLE;
            end else if (w_expired) begin
               w_retire     = 1'b1;
               w_timeout    = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rd        <= '0;
         r_reg_write <= 1'b0;
         r_is_load   <= 1'b0;
         r_we        <= 1'b0;
         r_killed    <= 1'b0;
         r_wb_valid  <= 1'b0;
         r_wb_alu    <= '0;
         r_wb_rdata  <= '0;
         r_wb        <= '0;
      end else begin
         r_state    <= w_next_state;
         r_wb_valid <= 1'b0;
         if (w_accept_mem) begin
            r_addr      <= in_alu_result;
            r_wdata     <= in_store_data;
            r_rd        <= in_rd;
            r_reg_write <= in_reg_write;
            r_is_load   <= in_mem_read;
            r_we        <= in_mem_write;
            r_killed    <= 1'b0;
         end else if (r_state != IDLE) begin
            r_killed <= w_kill;
         end
         // Killed ops retire silently: only the valid strobe stays low, fields hold.
         if (w_accept_alu) begin
            r_wb_valid        <= 1'b1;
            r_wb_alu          <= in_alu_result;
            r_wb.rd           <= in_rd;
            r_wb.reg_write    <= in_reg_write && (in_rd != '0);
            r_wb.mem_to_reg   <= 1'b0;
         end else if (w_retire && !w_kill) begin
            r_wb_valid        <= 1'b1;
            r_wb_alu          <= r_addr;
            r_wb.rd           <= r_rd;
            r_wb.reg_write    <= r_reg_write && (r_rd != '0) && r_is_load && !w_timeout;
            r_wb.mem_to_reg   <= r_is_load && !w_timeout;
            if (r_is_load && !w_timeout) begin
               r_wb_rdata <= dmem_rdata;
            end
         end
      end
   end

   assign in_ready      = (r_state == IDLE) && !reset;
   assign dmem_req      = (r_state == REQ);
   assign dmem_we       = (r_state == REQ) && r_we;
   assign dmem_addr     = r_addr;
   assign dmem_wdata    = r_wdata;
   assign mem_err       = w_timeout;
   assign wb_valid      = r_wb_valid;
   assign wb_alu_result = r_wb_alu;
   assign wb_read_data  = r_wb_rdata;
   assign wb_rd         = r_wb.rd;
   // Gating keeps the write-back mux select and write enable defined-low when idle.
   assign wb_mem_to_reg = r_wb_valid && r_wb.mem_to_reg;
   assign wb_reg_write  = r_wb_valid && r_wb.reg_write;

   a_no_rd_and_wr : assert property (@(posedge clk) disable iff (reset)
      !(in_valid && in_mem_read && in_mem_write));

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_wb_stage;

   localparam int W  = 32;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_alu_result = '0;
   logic [W-1:0]  in_store_data = '0;
   logic [4:0]    in_rd = '0;
   logic          in_reg_write = 1'b0;
   logic          in_mem_read = 1'b0;
   logic          in_mem_write = 1'b0;
   logic          flush = 1'b0;
   logic          dmem_req;
   logic          dmem_we;
   logic [W-1:0]  dmem_addr;
   logic [W-1:0]  dmem_wdata;
   logic          dmem_rvalid = 1'b0;
   logic [W-1:0]  dmem_rdata = '0;
   logic          wb_valid;
   logic [W-1:0]  wb_alu_result;
   logic [W-1:0]  wb_read_data;
   logic          wb_mem_to_reg;
   logic [4:0]    wb_rd;
   logic          wb_reg_write;
   logic          mem_err;

   int n_checks = 0;
   int n_fail   = 0;

   mem_wb_stage #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_alu_result (in_alu_result),
      .in_store_data (in_store_data),
      .in_rd         (in_rd),
      .in_reg_write  (in_reg_write),
      .in_mem_read   (in_mem_read),
      .in_mem_write  (in_mem_write),
      .flush         (flush),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_rvalid   (dmem_rvalid),
      .dmem_rdata    (dmem_rdata),
      .wb_valid      (wb_valid),
      .wb_alu_result (wb_alu_result),
      .wb_read_data  (wb_read_data),
      .wb_mem_to_reg (wb_mem_to_reg),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .mem_err       (mem_err)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   // The stage is either free or holding one memory op of a given age
   // (age 1 = request cycle, age n+1 = n-th wait cycle).
   bit          m_busy = 0;
   int          m_age = 0;
   bit          m_killed = 0;
   bit          m_load = 0;
   logic [W-1:0] m_addr = '0, m_data = '0;
   logic [4:0]  m_rd = '0;
   bit          m_rw = 0;
   bit          e_valid = 0, e_m2r = 0, e_rw = 0;
   logic [W-1:0] e_alu = '0, e_rdata = '0;
   logic [4:0]  e_rd = '0;

   always @(negedge clk) begin
      bit exp_req, exp_err, kill, tmo;
      int wait_n;
      if (reset) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_dmem_req", dmem_req, 0);
         chk("rst_dmem_we", dmem_we, 0);
         chk("rst_mem_err", mem_err, 0);
         chk("rst_wb_valid", wb_valid, 0);
         chk("rst_wb_m2r", wb_mem_to_reg, 0);
         chk("rst_wb_rw", wb_reg_write, 0);
         chk("rst_wb_alu", wb_alu_result, 0);
         chk("rst_wb_rdata", wb_read_data, 0);
         chk("rst_wb_rd", wb_rd, 0);
         m_busy = 0; m_age = 0; m_killed = 0;
         e_valid = 0; e_m2r = 0; e_rw = 0; e_alu = '0; e_rdata = '0; e_rd = '0;
      end else begin
         wait_n  = m_age - 1;
         exp_req = m_busy && (m_age == 1);
         exp_err = m_busy && (m_age >= 2) && !dmem_rvalid && (wait_n == TO);
         chk("in_ready", in_ready, !m_busy);
         chk("dmem_req", dmem_req, exp_req);
         chk("dmem_we", dmem_we, exp_req && !m_load);
         if (exp_req) begin
            chk("dmem_addr", dmem_addr, m_addr);
            chk("dmem_wdata", dmem_wdata, m_data);
         end
         chk("mem_err", mem_err, exp_err);
         chk("wb_valid", wb_valid, e_valid);
         chk("wb_mem_to_reg", wb_mem_to_reg, e_valid && e_m2r);
         chk("wb_reg_write", wb_reg_write, e_valid && e_rw);
         chk("wb_alu_result", wb_alu_result, e_alu);
         chk("wb_read_data", wb_read_data, e_rdata);
         chk("wb_rd", wb_rd, e_rd);
         // advance to the state after the coming rising edge
         e_valid = 0;
         if (!m_busy) begin
            if (in_valid && !flush) begin
               if (in_mem_read || in_mem_write) begin
                  m_busy = 1; m_age = 1; m_killed = 0; m_load = in_mem_read;
                  m_addr = in_alu_result; m_data = in_store_data;
                  m_rd = in_rd; m_rw = in_reg_write;
               end else begin
                  e_valid = 1; e_alu = in_alu_result; e_rd = in_rd;
                  e_rw = in_reg_write && (in_rd != 0); e_m2r = 0;
               end
            end
         end else begin
            kill = m_killed || flush;
            if (m_age == 1) begin
               m_age = 2; m_killed = kill;
            end else if (dmem_rvalid || (wait_n == TO)) begin
               tmo = !dmem_rvalid;
               if (!kill) begin
                  e_valid = 1; e_alu = m_addr; e_rd = m_rd;
                  e_rw  = m_load && !tmo && m_rw && (m_rd != 0);
                  e_m2r = m_load && !tmo;
                  if (m_load && !tmo) e_rdata = dmem_rdata;
               end
               m_busy = 0;
            end else begin
               m_age++; m_killed = kill;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle_inputs();
      in_valid = 0; in_mem_read = 0; in_mem_write = 0; in_reg_write = 0;
      flush = 0; dmem_rvalid = 0;
   endtask

   task automatic cyc();
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic op(input bit rd_en, input bit wr_en, input logic [31:0] alu,
                     input logic [31:0] sd, input logic [4:0] rd, input bit rw);
      in_valid = 1; in_mem_read = rd_en; in_mem_write = wr_en;
      in_alu_result = alu; in_store_data = sd; in_rd = rd; in_reg_write = rw;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 0;

      // ALU op
      cyc(); op(0, 0, 32'h0000_00AA, 32'h0, 5'd5, 1); #2;
      chk("t2_in_ready", in_ready, 1);
      cyc(); #2;
      chk("t2_wb_valid", wb_valid, 1);
      chk("t2_wb_alu", wb_alu_result, 32'hAA);
      chk("t2_wb_m2r", wb_mem_to_reg, 0);
      chk("t2_wb_rw", wb_reg_write, 1);
      chk("t2_wb_rd", wb_rd, 5);
      cyc(); #2;
      chk("t2_wb_valid_pulse", wb_valid, 0);

      // Load, response in the 4th wait cycle
      cyc(); op(1, 0, 32'h100, 32'h0, 5'd7, 1);
      cyc(); #2;
      chk("t3_req", dmem_req, 1);
      chk("t3_we", dmem_we, 0);
      chk("t3_addr", dmem_addr, 32'h100);
      chk("t3_in_ready", in_ready, 0);
      cyc(); #2;
      chk("t3_req_pulse", dmem_req, 0);
      cyc(); cyc(); cyc(); dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF;
      cyc(); #2;
      chk("t3_wb_valid", wb_valid, 1);
      chk("t3_wb_rdata", wb_read_data, 32'hDEAD_BEEF);
      chk("t3_wb_m2r", wb_mem_to_reg, 1);
      chk("t3_wb_rw", wb_reg_write, 1);
      chk("t3_wb_rd", wb_rd, 7);

      // Store
      cyc(); op(0, 1, 32'h200, 32'h1234, 5'd9, 1);
      cyc(); #2;
      chk("t4_we", dmem_we, 1);
      chk("t4_wdata", dmem_wdata, 32'h1234);
      chk("t4_addr", dmem_addr, 32'h200);
      cyc(); dmem_rvalid = 1; dmem_rdata = 32'h5555_0000;
      cyc(); #2;
      chk("t4_wb_valid", wb_valid, 1);
      chk("t4_wb_rw", wb_reg_write, 0);
      chk("t4_wb_m2r", wb_mem_to_reg, 0);
      chk("t4_wb_rdata_hold", wb_read_data, 32'hDEAD_BEEF);

      // Load killed by flush in the 2nd wait cycle
      cyc(); op(1, 0, 32'h300, 32'h0, 5'd3, 1);
      cyc(); cyc(); cyc(); flush = 1;
      cyc(); dmem_rvalid = 1; dmem_rdata = 32'h55;
      cyc(); op(0, 0, 32'h77, 32'h0, 5'd4, 1); #2;
      chk("t5_wb_valid", wb_valid, 0);
      chk("t5_in_ready", in_ready, 1);
      cyc(); #2;
      chk("t5_next_valid", wb_valid, 1);
      chk("t5_next_alu", wb_alu_result, 32'h77);
      chk("t5_rdata_hold", wb_read_data, 32'hDEAD_BEEF);

      // Timeout
      cyc(); op(1, 0, 32'h400, 32'h0, 5'd6, 1);
      cyc();
      for (int k = 1; k <= TO; k++) begin
         cyc(); #2;
         if (k == TO - 1) chk("t6_err_early", mem_err, 0);
         if (k == TO) begin
            chk("t6_err", mem_err, 1);
            chk("t6_busy", in_ready, 0);
         end
      end
      cyc(); #2;
      chk("t6_err_pulse", mem_err, 0);
      chk("t6_in_ready", in_ready, 1);
      chk("t6_wb_valid", wb_valid, 1);
      chk("t6_wb_rw", wb_reg_write, 0);
      chk("t6_wb_m2r", wb_mem_to_reg, 0);

      // Reset in the middle of a wait
      cyc(); op(1, 0, 32'h500, 32'h0, 5'd8, 1);
      cyc(); cyc(); cyc();
      reset = 1; #1;
      chk("t1_in_ready", in_ready, 0);
      chk("t1_req", dmem_req, 0);
      chk("t1_wb_valid", wb_valid, 0);
      chk("t1_wb_alu", wb_alu_result, 0);
      chk("t1_wb_rdata", wb_read_data, 0);
      chk("t1_addr", dmem_addr, 0);
      cyc(); reset = 0; dmem_rvalid = 1; dmem_rdata = 32'hBAD0_BAD0; #2;
      chk("t1_idle", in_ready, 1);
      cyc(); #2;
      chk("t1_late_rvalid", wb_valid, 0);
      chk("t1_late_rdata", wb_read_data, 0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int kind;
         cyc();
         reset = ($urandom_range(0, 399) == 0);
         kind = $urandom_range(0, 2);
         in_valid      = ($urandom_range(0, 9) < 7);
         in_mem_read   = (kind == 1);
         in_mem_write  = (kind == 2);
         in_alu_result = $urandom;
         in_store_data = $urandom;
         in_rd         = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         in_reg_write  = $urandom_range(0, 1);
         flush         = ($urandom_range(0, 99) < 7);
         dmem_rvalid   = ($urandom_range(0, 99) < 18);
         dmem_rdata    = $urandom;
      end
      cyc(); reset = 0;
      repeat (TO + 4) cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
